// File: rtl/pe_alu_pkg.sv
// rtl/pe_alu_pkg.sv - opcode constants and the shared saturating-add helper for the PE ALU
package pe_alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_PASSC = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd3;
    localparam logic [OP_W-1:0] OP_MADD  = 4'd4;
    localparam logic [OP_W-1:0] OP_MAC   = 4'd5;
    localparam logic [OP_W-1:0] OP_AND   = 4'd6;
    localparam logic [OP_W-1:0] OP_OR    = 4'd7;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd8;

    // Widest P_W+1 sum the helper can reduce; users must keep P_W+1 <= SAT_MAX_W.
    localparam int SAT_MAX_W = 128;

    typedef struct packed {
        logic [SAT_MAX_W-1:0] res;
        logic                 ovf;
    } sat_res_t;

    // sum holds a (p_w+1)-bit signed result sign-extended to SAT_MAX_W bits.
    // Overflow means the two top bits of the (p_w+1)-bit sum disagree; the
    // upper of those two is the true sign and picks the clamp direction.
    function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] sum,
                                         input int p_w, input logic sat);
        sat_res_t             r;
        logic [1:0]           top2;
        logic [SAT_MAX_W-1:0] max_v;
        top2  = 2'(sum >> (p_w - 1));
        max_v = (SAT_MAX_W'(1) << (p_w - 1)) - SAT_MAX_W'(1);
        r.ovf = top2[1] ^ top2[0];
        if (r.ovf && sat) begin
            r.res = top2[1] ? ~max_v : max_v;
        end else begin
            r.res = sum;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_alu_pipe_if.sv
// rtl/pe_alu_pipe_if.sv - operand/result bundle between PE decode and the pipelined ALU
// master: decode side (drives en/valid/op/operands, receives p/valid/flags)
// slave:  the ALU (pe_alu_pipe)
interface pe_alu_pipe_if import pe_alu_pkg::*; #(
    parameter int A_W = 27,
    parameter int B_W = 18,
    parameter int P_W = 48
) ();
    logic                  en_i;
    logic                  valid_i;
    logic [OP_W-1:0]       op_i;
    logic                  acc_clr_i;
    logic signed [A_W-1:0] a_i;
    logic signed [B_W-1:0] b_i;
    logic signed [P_W-1:0] c_i;
    logic signed [P_W-1:0] p_o;
    logic                  valid_o;
    logic                  ovf_o;
    logic                  ill_o;

    modport master (output en_i, valid_i, op_i, acc_clr_i, a_i, b_i, c_i,
                    input  p_o, valid_o, ovf_o, ill_o);
    modport slave  (input  en_i, valid_i, op_i, acc_clr_i, a_i, b_i, c_i,
                    output p_o, valid_o, ovf_o, ill_o);
endinterface

// File: rtl/pe_alu_core.sv
// rtl/pe_alu_core.sv - combinational stage-3 opcode mux with overflow detection and optional saturation
// op/acc_clr: stage-2 control; a: A sign-extended; prod: A*B sign-extended; c: operand C;
// acc: current P register; p/ovf/ill: next result and flags
module pe_alu_core import pe_alu_pkg::*; #(
    parameter int P_W = 48,
    parameter int SAT = 0
) (
    input  logic [OP_W-1:0]       op,
    input  logic                  acc_clr,
    input  logic signed [P_W-1:0] a,
    input  logic signed [P_W-1:0] prod,
    input  logic signed [P_W-1:0] c,
    input  logic signed [P_W-1:0] acc,
    output logic [P_W-1:0]        p,
    output logic                  ovf,
    output logic                  ill
);
    logic signed [P_W:0]   sum;
    logic signed [P_W-1:0] acc_src;
    logic                  arith;
    sat_res_t              sr;
    logic                  sat_unused;

    always_comb begin
        sum     = '0;
        arith   = 1'b0;
        p       = '0;
        ovf     = 1'b0;
        ill     = 1'b0;
        acc_src = acc_clr ? '0 : acc;
        case (op)
            OP_PASSC: p = c;
            OP_ADD:   begin sum = (P_W+1)'(a) + (P_W+1)'(c);          arith = 1'b1; end
            OP_SUB:   begin sum = (P_W+1)'(c) - (P_W+1)'(a);          arith = 1'b1; end
            OP_MUL:   p = prod;
            OP_MADD:  begin sum = (P_W+1)'(prod) + (P_W+1)'(c);       arith = 1'b1; end
            OP_MAC:   begin sum = (P_W+1)'(acc_src) + (P_W+1)'(prod); arith = 1'b1; end
            OP_AND:   p = a & c;
            OP_OR:    p = a | c;
            OP_XOR:   p = a ^ c;
            default:  ill = 1'b1;
        endcase
        sr = sat_add(SAT_MAX_W'(sum), P_W, SAT != 0);
        if (arith) begin
            p   = sr.res[P_W-1:0];
            ovf = sr.ovf;
        end
    end

    assign sat_unused = ^sr.res[SAT_MAX_W-1:P_W];

endmodule

// File: rtl/pe_alu_pipe.sv
// rtl/pe_alu_pipe.sv - 3-stage pipelined width-generic PE ALU with MAC accumulator and global stall
// clk/rst: clock, synchronous active-high reset
// bus (slave): en_i stall control, valid_i/op_i/acc_clr_i/a_i/b_i/c_i in; p_o/valid_o/ovf_o/ill_o out
module pe_alu_pipe import pe_alu_pkg::*; #(
    parameter int A_W = 27,
    parameter int B_W = 18,
    parameter int P_W = 48,
    parameter int SAT = 0
) (
    input logic          clk,
    input logic          rst,
    pe_alu_pipe_if.slave bus
);
    if (A_W + B_W > P_W) begin : g_bad_width
        $fatal(1, "pe_alu_pipe: A_W+B_W must not exceed P_W");
    end
    if (P_W + 1 > SAT_MAX_W) begin : g_bad_pw
        $fatal(1, "pe_alu_pipe: P_W too wide for sat_add");
    end

    // Stage 1
    logic                  v1_q, v1_d, clr1_q, clr1_d;
    logic [OP_W-1:0]       op1_q, op1_d;
    logic signed [A_W-1:0] a1_q, a1_d;
    logic signed [B_W-1:0] b1_q, b1_d;
    logic signed [P_W-1:0] c1_q, c1_d;
    // Stage 2
    logic                  v2_q, v2_d, clr2_q, clr2_d;
    logic [OP_W-1:0]       op2_q, op2_d;
    logic signed [P_W-1:0] a2_q, a2_d, prod2_q, prod2_d, c2_q, c2_d;
    // Stage 3 (P doubles as the MAC accumulator)
    logic                  v3_q, v3_d, ovf_q, ovf_d, ill_q, ill_d;
    logic signed [P_W-1:0] p_q, p_d;

    logic signed [A_W+B_W-1:0] prod_full;
    logic [P_W-1:0]            core_p;
    logic                      core_ovf, core_ill;

    assign prod_full = (A_W+B_W)'(a1_q) * (A_W+B_W)'(b1_q);

    pe_alu_core #(.P_W(P_W), .SAT(SAT)) u_core (
        .op      (op2_q),
        .acc_clr (clr2_q),
        .a       (a2_q),
        .prod    (prod2_q),
        .c       (c2_q),
        .acc     (p_q),
        .p       (core_p),
        .ovf     (core_ovf),
        .ill     (core_ill)
    );

    always_comb begin
        v1_d = v1_q; op1_d = op1_q; clr1_d = clr1_q; a1_d = a1_q; b1_d = b1_q; c1_d = c1_q;
        v2_d = v2_q; op2_d = op2_q; clr2_d = clr2_q; a2_d = a2_q; prod2_d = prod2_q; c2_d = c2_q;
        v3_d = v3_q; p_d = p_q; ovf_d = ovf_q; ill_d = ill_q;
        if (bus.en_i) begin
            v1_d    = bus.valid_i;
            op1_d   = bus.op_i;
            clr1_d  = bus.valid_i & bus.acc_clr_i;
            a1_d    = bus.a_i;
            b1_d    = bus.b_i;
            c1_d    = bus.c_i;
            v2_d    = v1_q;
            op2_d   = op1_q;
            clr2_d  = clr1_q;
            a2_d    = P_W'(a1_q);
            prod2_d = P_W'(prod_full);
            c2_d    = c1_q;
            v3_d    = v2_q;
            // A bubble keeps P (the accumulator) and clears the flags.
            if (v2_q) begin
                p_d   = core_p;
                ovf_d = core_ovf;
                ill_d = core_ill;
            end else begin
                ovf_d = 1'b0;
                ill_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; op1_q <= '0; clr1_q <= 1'b0; a1_q <= '0; b1_q <= '0; c1_q <= '0;
            v2_q <= 1'b0; op2_q <= '0; clr2_q <= 1'b0; a2_q <= '0; prod2_q <= '0; c2_q <= '0;
            v3_q <= 1'b0; p_q <= '0; ovf_q <= 1'b0; ill_q <= 1'b0;
        end else begin
            v1_q <= v1_d; op1_q <= op1_d; clr1_q <= clr1_d; a1_q <= a1_d; b1_q <= b1_d; c1_q <= c1_d;
            v2_q <= v2_d; op2_q <= op2_d; clr2_q <= clr2_d; a2_q <= a2_d; prod2_q <= prod2_d; c2_q <= c2_d;
            v3_q <= v3_d; p_q <= p_d; ovf_q <= ovf_d; ill_q <= ill_d;
        end
    end

    assign bus.p_o     = p_q;
    assign bus.valid_o = v3_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.ill_o   = ill_q;

endmodule

// File: tb/tb_pe_alu_pipe.sv
// tb/tb_pe_alu_pipe.sv - directed self-checking bench for pe_alu_pipe (wrap and saturate builds)
module tb_pe_alu_pipe;
    import pe_alu_pkg::*;

    localparam int A_W = 27;
    localparam int B_W = 18;
    localparam int P_W = 48;
    localparam longint MAXP = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint MINP = 64'shFFFF_8000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  en, vi, clr;
    logic [OP_W-1:0]       op;
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic signed [P_W-1:0] c;

    int n_vec = 0;
    int n_err = 0;

    pe_alu_pipe_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus0 ();
    pe_alu_pipe_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus1 ();

    assign bus0.en_i = en;  assign bus0.valid_i = vi; assign bus0.op_i = op; assign bus0.acc_clr_i = clr;
    assign bus0.a_i  = a;   assign bus0.b_i     = b;  assign bus0.c_i  = c;
    assign bus1.en_i = en;  assign bus1.valid_i = vi; assign bus1.op_i = op; assign bus1.acc_clr_i = clr;
    assign bus1.a_i  = a;   assign bus1.b_i     = b;  assign bus1.c_i  = c;

    pe_alu_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pe_alu_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // {valid_o, ovf_o, ill_o, p_o}
    logic [P_W+2:0] obs0, obs1;
    assign obs0 = {bus0.valid_o, bus0.ovf_o, bus0.ill_o, bus0.p_o};
    assign obs1 = {bus1.valid_o, bus1.ovf_o, bus1.ill_o, bus1.p_o};

    function automatic logic [P_W+2:0] ex(input logic v, input logic o, input logic il, input longint pv);
        return {v, o, il, P_W'(pv)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OP_W-1:0] o, input logic cl,
                         input longint av, input longint bv, input longint cv);
        vi = v; op = o; clr = cl; a = A_W'(av); b = B_W'(bv); c = P_W'(cv);
    endtask

    task automatic idle();
        drive(1'b0, OP_PASSC, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [P_W+2:0] e;
        rst = 1'b1; en = 1'b1; idle();
        step(); step();
        e = ex(0, 0, 0, 0);
        n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL reset sat0: got %h want %h", obs0, e); end
        n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL reset sat1: got %h want %h", obs1, e); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [P_W+2:0] e;
        drive(1'b1, OP_ADD, 1'b0, 5, 0, 7);
        for (int k = 1; k <= 4; k++) begin
            step();
            idle();
            e = (k == 3) ? ex(1, 0, 0, 12) : ex(0, 0, 0, (k == 4) ? 12 : 0);
            n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL latency[%0d] sat0: got %h want %h", k, obs0, e); end
            n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL latency[%0d] sat1: got %h want %h", k, obs1, e); end
        end
    endtask

    task automatic test_mac_chain();
        longint av[3] = '{3, 2, -1};
        longint bv[3] = '{4, 5, 6};
        longint ev[3] = '{12, 22, 16};
        logic [P_W+2:0] e;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b1, OP_MAC, k == 0, av[k], bv[k], 0);
            else idle();
            step();
            if (k >= 2) begin
                e = ex(1, 0, 0, ev[k-2]);
                n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL mac[%0d] sat0: got %h want %h", k-2, obs0, e); end
                n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL mac[%0d] sat1: got %h want %h", k-2, obs1, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] ot[8] = '{OP_MADD, OP_AND, OP_OR, OP_XOR, OP_PASSC, OP_MAC, OP_SUB, OP_MUL};
        logic            ct[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        longint av[8] = '{-3, -1, 'h0F, 'hF0, 0, 1, 10, -100};
        longint bv[8] = '{5, 0, 0, 0, 0, 1, 0, -100};
        longint cv[8] = '{100, 'h1234, 'hF0, 'hFF, -9, 0, 3, 0};
        longint ev[8] = '{85, 'h1234, 'hFF, 'h0F, -9, -8, -7, 10000};
        logic [P_W+2:0] e;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, ot[k], ct[k], av[k], bv[k], cv[k]);
            else idle();
            step();
            if (k >= 2) begin
                e = ex(1, 0, 0, ev[k-2]);
                n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL ops[%0d] sat0: got %h want %h", k-2, obs0, e); end
                n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL ops[%0d] sat1: got %h want %h", k-2, obs1, e); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [OP_W-1:0] ot[4] = '{OP_ADD, OP_SUB, OP_MADD, OP_ADD};
        longint av[4] = '{1, 1, 1, 1};
        longint bv[4] = '{0, 0, 1, 0};
        longint cv[4] = '{MAXP, MINP, MAXP, MAXP - 1};
        logic   ov[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        longint e0[4] = '{MINP, MAXP, MINP, MAXP};
        longint e1[4] = '{MAXP, MINP, MAXP, MAXP};
        logic [P_W+2:0] e;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b1, ot[k], 1'b0, av[k], bv[k], cv[k]);
            else idle();
            step();
            if (k >= 2) begin
                e = ex(1, ov[k-2], 0, e0[k-2]);
                n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL ovf_wrap[%0d]: got %h want %h", k-2, obs0, e); end
                e = ex(1, ov[k-2], 0, e1[k-2]);
                n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL ovf_sat[%0d]: got %h want %h", k-2, obs1, e); end
            end
        end
        step(); step();
    endtask

    task automatic test_stall();
        logic [P_W+2:0] e;
        drive(1'b1, OP_MUL, 1'b0, -3, 7, 0);
        step();
        idle();
        en = 1'b0;
        e = ex(0, 0, 0, MAXP);
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL stall_hold[%0d] sat0: got %h want %h", k, obs0, e); end
        end
        en = 1'b1;
        step();
        n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL stall_early sat0: got %h want %h", obs0, e); end
        step();
        e = ex(1, 0, 0, -21);
        n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL stall_result sat0: got %h want %h", obs0, e); end
        n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL stall_result sat1: got %h want %h", obs1, e); end
        step();
        e = ex(0, 0, 0, -21);
        n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL stall_dup sat0: got %h want %h", obs0, e); end
    endtask

    task automatic test_bubble_illegal();
        logic            vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [OP_W-1:0] ot[5] = '{OP_ADD, OP_PASSC, OP_ADD, OP_PASSC, 4'd12};
        longint av[5] = '{1, 0, 2, 0, 5};
        longint cv[5] = '{1, 0, 2, 0, 9};
        logic [P_W+2:0] et[6];
        et[0] = ex(1, 0, 0, 2); et[1] = ex(0, 0, 0, 2); et[2] = ex(1, 0, 0, 4);
        et[3] = ex(0, 0, 0, 4); et[4] = ex(1, 0, 1, 0); et[5] = ex(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            if (k < 5) drive(vt[k], ot[k], 1'b0, av[k], 0, cv[k]);
            else idle();
            step();
            if (k >= 2) begin
                n_vec++; if (obs0 !== et[k-2]) begin n_err++; $display("FAIL bubble[%0d] sat0: got %h want %h", k-2, obs0, et[k-2]); end
                n_vec++; if (obs1 !== et[k-2]) begin n_err++; $display("FAIL bubble[%0d] sat1: got %h want %h", k-2, obs1, et[k-2]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [P_W+2:0] e;
        drive(1'b1, OP_ADD, 1'b0, 1, 0, 99);
        step(); idle(); step(); step();
        e = ex(1, 0, 0, 100);
        n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL pre_reset sat0: got %h want %h", obs0, e); end
        drive(1'b1, OP_ADD, 1'b0, 1, 0, 1);  step();
        drive(1'b1, OP_ADD, 1'b0, 2, 0, 2);  step();
        drive(1'b1, OP_ADD, 1'b0, 3, 0, 3);  rst = 1'b1; step();
        rst = 1'b0; idle();
        e = ex(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (obs0 !== e) begin n_err++; $display("FAIL midreset[%0d] sat0: got %h want %h", k, obs0, e); end
            n_vec++; if (obs1 !== e) begin n_err++; $display("FAIL midreset[%0d] sat1: got %h want %h", k, obs1, e); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mac_chain();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_bubble_illegal();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
